sd_spi_led_status_ctrl: RTL and testbench

Status sequencer that owns the 6-bit board LED bank for the SD-over-SPI subsystem. It latches the first error event and its 4-bit code, then sequences a repeating blink-count pattern on led[0]. It also drives a heartbeat, an activity stretcher, an init indicator and a sticky error light. It sits between the SD SPI controller status outputs and the LED pins, and takes over sole ownership of the LED bank from the plain sticky error latch.

---
 rtl/sd_spi_led_status_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sd_spi_led_status_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_led_status_ctrl.sv
// LED bank owner for the SD-over-SPI subsystem: first-error latch with a
// blink-count code on led[0], plus heartbeat, activity stretcher, init and sticky error lights.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no error pending, led[0] dark, blink prescaler held at 0
// S_ON   | blink lit; code 0 stays here forever (solid on)
// S_OFF  | blink dark between pulses
// S_GAP  | dark gap after the last pulse of a sequence
module sd_spi_led_status_ctrl #(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned BLINK_TICKS   = 200,
    parameter int unsigned GAP_TICKS     = 1000,
    parameter int unsigned HB_TICKS      = 500,
    parameter int unsigned STRETCH_TICKS = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       error_flag,
    input  logic [3:0] error_code,
    input  logic       busy,
    input  logic       init_done,
    input  logic       clear,
    output logic [5:0] led,
    output logic [3:0] err_code_q
);

    localparam int unsigned TD_W   = $clog2(TICK_DIV);
    localparam int unsigned PH_MAX = (BLINK_TICKS > GAP_TICKS) ? BLINK_TICKS : GAP_TICKS;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned HB_W   = $clog2(HB_TICKS + 1);
    localparam int unsigned ST_W   = $clog2(STRETCH_TICKS + 1);

    localparam logic [TD_W-1:0] TD_LAST    = TD_W'(TICK_DIV - 1);
    localparam logic [PH_W-1:0] BLINK_LOAD = PH_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LOAD   = PH_W'(GAP_TICKS - 1);
    localparam logic [HB_W-1:0] HB_LAST    = HB_W'(HB_TICKS - 1);
    localparam logic [ST_W-1:0] ST_LOAD    = ST_W'(STRETCH_TICKS);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      blink_cnt_q, blink_cnt_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [TD_W-1:0] bpre_q, bpre_d;
    logic [TD_W-1:0] fpre_q, fpre_d;
    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic [ST_W-1:0] str_q, str_d;
    logic            hb_q, hb_d;
    logic            act_q, act_d;
    logic            init_q, init_d;
    logic            led0_q, led0_d;
    logic            err_pend_q, err_pend_d;
    logic [3:0]      err_code_d;
    logic            capture, btick, ftick;

    always_comb begin
        // clear frees the latch in the same cycle, so a coincident error is captured
        capture = error_flag && (!err_pend_q || clear);
        btick   = (bpre_q == TD_LAST);
        ftick   = (fpre_q == TD_LAST);

        err_pend_d  = err_pend_q;
        err_code_d  = err_code_q;
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        bpre_d      = bpre_q;
        fpre_d      = fpre_q;
        hb_cnt_d    = hb_cnt_q;
        hb_d        = hb_q;
        str_d       = str_q;

        if (capture) begin
            err_pend_d = 1'b1;
            err_code_d = error_code;
        end else if (clear) begin
            err_pend_d = 1'b0;
            err_code_d = 4'd0;
        end

        if (capture || clear || state_q == S_IDLE) begin
            bpre_d = '0;
        end else if (btick) begin
            bpre_d = '0;
        end else begin
            bpre_d = bpre_q + TD_W'(1);
        end

        if (capture) begin
            state_d     = S_ON;
            blink_cnt_d = 4'd0;
            phase_d     = BLINK_LOAD;
        end else if (clear) begin
            state_d     = S_IDLE;
            blink_cnt_d = 4'd0;
            phase_d     = '0;
        end else if (btick) begin
            if (phase_q != '0) begin
                phase_d = phase_q - PH_W'(1);
            end else begin
                case (state_q)
                    S_ON: begin
                        if (err_code_q != 4'd0) begin
                            blink_cnt_d = blink_cnt_q + 4'd1;
                            state_d     = S_OFF;
                            phase_d     = BLINK_LOAD;
                        end
                    end
                    S_OFF: begin
                        if (blink_cnt_q == err_code_q) begin
                            state_d = S_GAP;
                            phase_d = GAP_LOAD;
                        end else begin
                            state_d = S_ON;
                            phase_d = BLINK_LOAD;
                        end
                    end
                    S_GAP: begin
                        blink_cnt_d = 4'd0;
                        state_d     = S_ON;
                        phase_d     = BLINK_LOAD;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        led0_d = (state_d == S_ON);

        fpre_d = ftick ? '0 : fpre_q + TD_W'(1);

        if (!init_done) begin
            hb_cnt_d = '0;
            hb_d     = 1'b0;
        end else if (ftick) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_d     = ~hb_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HB_W'(1);
            end
        end

        if (busy) begin
            str_d = ST_LOAD;
        end else if (ftick && str_q != '0) begin
            str_d = str_q - ST_W'(1);
        end
        act_d  = busy || (str_d != '0);
        init_d = init_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            blink_cnt_q <= 4'd0;
            phase_q     <= '0;
            bpre_q      <= '0;
            fpre_q      <= '0;
            hb_cnt_q    <= '0;
            hb_q        <= 1'b0;
            str_q       <= '0;
            act_q       <= 1'b0;
            init_q      <= 1'b0;
            led0_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            err_code_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            bpre_q      <= bpre_d;
            fpre_q      <= fpre_d;
            hb_cnt_q    <= hb_cnt_d;
            hb_q        <= hb_d;
            str_q       <= str_d;
            act_q       <= act_d;
            init_q      <= init_d;
            led0_q      <= led0_d;
            err_pend_q  <= err_pend_d;
            err_code_q  <= err_code_d;
        end
    end

    assign led = {err_pend_q, 1'b0, init_q, act_q, hb_q, led0_q};

endmodule

// File: tb/tb_sd_spi_led_status_ctrl.sv
// Randomized bench for sd_spi_led_status_ctrl: blink pattern is predicted from
// time-since-capture arithmetic; heartbeat and activity are checked by measured intervals.
module tb_sd_spi_led_status_ctrl;

    localparam int TD = 4;
    localparam int BT = 2;
    localparam int GT = 6;
    localparam int HT = 5;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       error_flag = 1'b0;
    logic [3:0] error_code = 4'd0;
    logic       busy = 1'b0;
    logic       init_done = 1'b0;
    logic       clear = 1'b0;
    logic [5:0] led;
    logic [3:0] err_code_q;

    always #5 clk = ~clk;

    sd_spi_led_status_ctrl #(
        .TICK_DIV(TD), .BLINK_TICKS(BT), .GAP_TICKS(GT), .HB_TICKS(HT), .STRETCH_TICKS(ST)
    ) dut (
        .clk(clk), .reset_n(reset_n), .error_flag(error_flag), .error_code(error_code),
        .busy(busy), .init_done(init_done), .clear(clear), .led(led), .err_code_q(err_code_q)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // reference: pending flag, latched code, clocks elapsed since the capture edge
    bit m_pend = 1'b0;
    int m_code = 0;
    int m_t    = 0;

    function automatic bit blink_on(input int t, input int code);
        int ph, seq, pos;
        if (code == 0) return 1'b1;
        ph  = BT * TD;
        seq = code * 2 * ph + GT * TD;
        pos = t % seq;
        return (pos < code * 2 * ph) && ((pos % (2 * ph)) < ph);
    endfunction

    task automatic step(input bit ef, input bit [3:0] ec, input bit clr);
        error_flag = ef;
        error_code = ec;
        clear      = clr;
        @(posedge clk);
        if (ef && (!m_pend || clr)) begin
            m_pend = 1'b1; m_code = ec; m_t = 0;
        end else if (clr) begin
            m_pend = 1'b0; m_code = 0; m_t = 0;
        end else if (m_pend) begin
            m_t++;
        end
        #1;
        chk("led0_blink", led[0], m_pend && blink_on(m_t, m_code));
        chk("led5_pend", led[5], m_pend);
        chk("err_code", err_code_q, m_code);
        chk("led4_zero", led[4], 0);
        chk("led3_init", led[3], init_done);
        error_flag = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic run_idle(input int n, input bit spurious);
        for (int i = 0; i < n; i++) begin
            if (spurious && $urandom_range(0, 9) == 0)
                step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            else
                step(1'b0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        int hi, n;
        bit prev, found, stayed;

        // reset held: random inputs must not disturb anything
        for (int i = 0; i < 10; i++) begin
            error_flag = 1'($urandom_range(0, 1));
            error_code = 4'($urandom_range(0, 15));
            busy       = 1'($urandom_range(0, 1));
            init_done  = 1'($urandom_range(0, 1));
            clear      = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("rst_led", led, 0);
            chk("rst_code", err_code_q, 0);
        end
        error_flag = 0; error_code = 0; busy = 0; init_done = 0; clear = 0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd0, 1'b0);
            chk("post_rst_led", led, 0);
        end

        // code 3 with ignored follow-up errors
        step(1'b1, 4'd3, 1'b0);
        run_idle(150, 1'b1);

        // first error wins, clear, simultaneous clear+error
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd2, 1'b0);
        run_idle(5, 1'b0);
        step(1'b1, 4'd5, 1'b0);
        run_idle(20, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        chk("clr_led", led, 0);
        run_idle(3, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        run_idle(11, 1'b0);
        step(1'b1, 4'd1, 1'b1);
        run_idle(40, 1'b0);

        // code 0 solid, then code 15 full sequence
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd0, 1'b0);
        run_idle(210, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd15, 1'b0);
        hi = int'(led[0]);
        for (int i = 1; i < 15 * 2 * BT * TD + GT * TD; i++) begin
            step(1'b0, 4'd0, 1'b0);
            hi += int'(led[0]);
        end
        chk("c15_lit_clocks", hi, 15 * BT * TD);
        run_idle(20, 1'b0);

        // randomized rounds: random code, spurious errors, stray clears
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
            else begin
                step(1'b0, 4'd0, 1'b1);
                step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            end
            for (int i = 0; i < $urandom_range(20, 150); i++) begin
                case ($urandom_range(0, 59))
                    0:       step(1'b0, 4'd0, 1'b1);
                    1:       step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
                    2, 3, 4: step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
                    default: step(1'b0, 4'd0, 1'b0);
                endcase
            end
        end
        step(1'b0, 4'd0, 1'b1);

        // heartbeat
        init_done = 1'b1;
        step(1'b0, 4'd0, 1'b0);
        prev = led[1];
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 4'd0, 1'b0);
            if (led[1] != prev) found = 1'b1;
        end
        chk("hb_first_toggle", found, 1);
        for (int k = 0; k < 2; k++) begin
            prev = led[1];
            n = 0;
            for (int i = 0; i < 40; i++) begin
                step(1'b0, 4'd0, 1'b0);
                n++;
                if (led[1] != prev) break;
            end
            chk("hb_period", n, HT * TD);
        end
        init_done = 1'b0;
        step(1'b0, 4'd0, 1'b0);
        chk("hb_off", led[1], 0);

        // activity stretcher
        busy = 1'b1;
        run_idle(10, 1'b0);
        chk("act_busy", led[2], 1);
        busy = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
            if (led[2] == 1'b0) break;
        end
        chk("act_drop_in_9_12", (n >= 9 && n <= 12), 1);
        busy = 1'b1;
        run_idle(5, 1'b0);
        busy = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0, 1'b0);
            if (led[2] != 1'b1) stayed = 1'b0;
        end
        busy = 1'b1;
        step(1'b0, 4'd0, 1'b0);
        if (led[2] != 1'b1) stayed = 1'b0;
        busy = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
            if (led[2] == 1'b0) break;
        end
        chk("act_extend_held", stayed, 1);
        chk("act_extend_drop", (n >= 9 && n <= 12), 1);

        // asynchronous reset in the middle of an ON phase
        init_done = 1'b1;
        step(1'b1, 4'd3, 1'b0);
        run_idle(3, 1'b0);
        chk("pre_rst_on", led[0], 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_led", led, 0);
        chk("async_rst_code", err_code_q, 0);
        m_pend = 1'b0; m_code = 0; m_t = 0;
        init_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run_idle(50, 1'b0);
        step(1'b1, 4'd4, 1'b0);
        run_idle(80, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
